// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
// Frame-synchronous motion controller for the bouncing sprite. One update
// sequence runs per VGA refresh pulse: wall check / direction update, then a
// position step by the programmable speed, then a one-cycle done pulse.
//
// Optional feature macro: MOTION_CLAMP_EN
//   defined   : MOVE saturates the position to [XMIN,XMAX] / [YMIN,YMAX]
//   undefined : plain add/subtract, floored at 0 and capped at SCREEN-SPRITE
//
// Ports
//   CLK          system clock
//   RESET        synchronous active-high reset
//   REFRESH      one-cycle frame pulse from the VGA interface
//   PAUSE        level; frames are skipped while high
//   SPEED_IN     new speed value (pixels/frame)
//   SPEED_WE     one-cycle write strobe for SPEED_IN
//   X_OUT/Y_OUT  sprite left/top edge
//   DIR_X/DIR_Y  1 = increasing coordinate, 0 = decreasing
//   BOUNCE       one-cycle pulse when a direction bit changed
//   UPDATE_DONE  one-cycle pulse when the new position is valid
//   BUSY         high whenever the sequencer is not idle
//
// state | meaning
// IDLE  | waiting for a refresh (or a pending one) with PAUSE low
// CHECK | wall check, direction update, speed latched into working register
// MOVE  | position stepped by the working speed
// DONE  | UPDATE_DONE pulse, then back to IDLE
module sprite_motion_ctrl #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int SPRITE_W   = 80,
  parameter int SPRITE_H   = 80,
  parameter int MARGIN     = 5,
  parameter int INIT_X     = 280,
  parameter int INIT_Y     = 200,
  parameter int INIT_SPEED = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REFRESH,
  input  logic       PAUSE,
  input  logic [3:0] SPEED_IN,
  input  logic       SPEED_WE,
  output logic [9:0] X_OUT,
  output logic [8:0] Y_OUT,
  output logic       DIR_X,
  output logic       DIR_Y,
  output logic       BOUNCE,
  output logic       UPDATE_DONE,
  output logic       BUSY
);

  localparam logic [10:0] XMIN_L = 11'(MARGIN);
  localparam logic [10:0] XMAX_L = 11'(SCREEN_W - 1 - SPRITE_W - MARGIN);
  localparam logic [10:0] XCAP_L = 11'(SCREEN_W - SPRITE_W);
  localparam logic [9:0]  YMIN_L = 10'(MARGIN);
  localparam logic [9:0]  YMAX_L = 10'(SCREEN_H - 1 - SPRITE_H - MARGIN);
  localparam logic [9:0]  YCAP_L = 10'(SCREEN_H - SPRITE_H);

  typedef enum logic [1:0] {IDLE, CHECK, MOVE, DONE} state_t;

  state_t     state_q;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       dir_x_q, dir_x_d;
  logic       dir_y_q, dir_y_d;
  logic [3:0] speed_q, speed_work_q;
  logic       pending_q, bounce_q, done_q, busy_q;

  // One extra bit of headroom: the top bit of a difference flags underflow.
  logic [10:0] x_ext, x_sum, x_diff;
  logic [9:0]  y_ext, y_sum, y_diff;

  always_comb begin
    x_ext  = {1'b0, x_q};
    y_ext  = {1'b0, y_q};
    x_sum  = x_ext + {7'd0, speed_work_q};
    x_diff = x_ext - {7'd0, speed_work_q};
    y_sum  = y_ext + {6'd0, speed_work_q};
    y_diff = y_ext - {6'd0, speed_work_q};

    dir_x_d = dir_x_q;
    if (x_ext >= XMAX_L)      dir_x_d = 1'b0;
    else if (x_ext <= XMIN_L) dir_x_d = 1'b1;
    dir_y_d = dir_y_q;
    if (y_ext >= YMAX_L)      dir_y_d = 1'b0;
    else if (y_ext <= YMIN_L) dir_y_d = 1'b1;

`ifdef MOTION_CLAMP_EN
    if (dir_x_q) x_d = (x_sum > XMAX_L) ? XMAX_L[9:0] : x_sum[9:0];
    else         x_d = (x_diff[10] || x_diff < XMIN_L) ? XMIN_L[9:0] : x_diff[9:0];
    if (dir_y_q) y_d = (y_sum > YMAX_L) ? YMAX_L[8:0] : y_sum[8:0];
    else         y_d = (y_diff[9] || y_diff < YMIN_L) ? YMIN_L[8:0] : y_diff[8:0];
`else
    if (dir_x_q) x_d = (x_sum > XCAP_L) ? XCAP_L[9:0] : x_sum[9:0];
    else         x_d = x_diff[10] ? 10'd0 : x_diff[9:0];
    if (dir_y_q) y_d = (y_sum > YCAP_L) ? YCAP_L[8:0] : y_sum[8:0];
    else         y_d = y_diff[9] ? 9'd0 : y_diff[8:0];
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      x_q          <= 10'(INIT_X);
      y_q          <= 9'(INIT_Y);
      dir_x_q      <= 1'b0;
      dir_y_q      <= 1'b0;
      speed_q      <= 4'(INIT_SPEED);
      speed_work_q <= 4'(INIT_SPEED);
      pending_q    <= 1'b0;
      bounce_q     <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      bounce_q <= 1'b0;
      done_q   <= 1'b0;
      if (SPEED_WE) speed_q <= SPEED_IN;
      // Refreshes during a sequence collapse into a single pending update.
      if (REFRESH && state_q != IDLE) pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if ((REFRESH || pending_q) && !PAUSE) begin
            state_q   <= CHECK;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        CHECK: begin
          dir_x_q      <= dir_x_d;
          dir_y_q      <= dir_y_d;
          bounce_q     <= (dir_x_d != dir_x_q) || (dir_y_d != dir_y_q);
          speed_work_q <= speed_q;
          state_q      <= MOVE;
        end
        MOVE: begin
          x_q     <= x_d;
          y_q     <= y_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign X_OUT       = x_q;
  assign Y_OUT       = y_q;
  assign DIR_X       = dir_x_q;
  assign DIR_Y       = dir_y_q;
  assign BOUNCE      = bounce_q;
  assign UPDATE_DONE = done_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
module tb_sprite_motion_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REFRESH = 1'b0;
  logic       PAUSE = 1'b0;
  logic [3:0] SPEED_IN = 4'd0;
  logic       SPEED_WE = 1'b0;
  logic [9:0] X_OUT;
  logic [8:0] Y_OUT;
  logic       DIR_X, DIR_Y, BOUNCE, UPDATE_DONE, BUSY;

  sprite_motion_ctrl dut (
    .CLK(CLK), .RESET(RESET), .REFRESH(REFRESH), .PAUSE(PAUSE),
    .SPEED_IN(SPEED_IN), .SPEED_WE(SPEED_WE),
    .X_OUT(X_OUT), .Y_OUT(Y_OUT), .DIR_X(DIR_X), .DIR_Y(DIR_Y),
    .BOUNCE(BOUNCE), .UPDATE_DONE(UPDATE_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int x;
    int y;
    int dx;
    int dy;
    int b;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference position state, advanced once per expected update.
  int mx = 280, my = 200, mdx = 0, mdy = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_frame(input int spd);
    int ndx, ndy;
    exp_t e;
    ndx = mdx;
    ndy = mdy;
    if (mx >= 554) ndx = 0; else if (mx <= 5) ndx = 1;
    if (my >= 394) ndy = 0; else if (my <= 5) ndy = 1;
    e.b = (ndx != mdx || ndy != mdy) ? 1 : 0;
    mdx = ndx;
    mdy = ndy;
`ifdef MOTION_CLAMP_EN
    if (mdx == 1) mx = (mx + spd > 554) ? 554 : mx + spd;
    else          mx = (mx - spd < 5)   ? 5   : mx - spd;
    if (mdy == 1) my = (my + spd > 394) ? 394 : my + spd;
    else          my = (my - spd < 5)   ? 5   : my - spd;
`else
    if (mdx == 1) mx = (mx + spd > 560) ? 560 : mx + spd;
    else          mx = (mx - spd < 0)   ? 0   : mx - spd;
    if (mdy == 1) my = (my + spd > 400) ? 400 : my + spd;
    else          my = (my - spd < 0)   ? 0   : my - spd;
`endif
    e.x = mx;
    e.y = my;
    e.dx = mdx;
    e.dy = mdy;
    exp_q.push_back(e);
  endtask

  // Monitor: scoreboard pop on every UPDATE_DONE.
  initial begin
    int seen_b;
    exp_t e;
    seen_b = 0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        seen_b = 0;
      end else begin
        if (BOUNCE) seen_b = 1;
        if (UPDATE_DONE) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_update: got UPDATE_DONE, expected none at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("sb_x_out", int'(X_OUT), e.x);
            check("sb_y_out", int'(Y_OUT), e.y);
            check("sb_dir_x", int'(DIR_X), e.dx);
            check("sb_dir_y", int'(DIR_Y), e.dy);
            check("sb_bounce", seen_b, e.b);
          end
          seen_b = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse();
    REFRESH = 1'b1;
    tick();
    REFRESH = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (BUSY && k < 20) begin
      tick();
      k++;
    end
    check("idle_timeout_busy", int'(BUSY), 0);
  endtask

  task automatic frame(input int spd);
    model_frame(spd);
    pulse();
    wait_idle();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_x", int'(X_OUT), 280);
    check("rst_y", int'(Y_OUT), 200);
    check("rst_dir_x", int'(DIR_X), 0);
    check("rst_dir_y", int'(DIR_Y), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(UPDATE_DONE), 0);
    check("rst_bounce", int'(BOUNCE), 0);
    RESET = 1'b0;
    tick();

    // Frame 1 with cycle-accurate timing.
    model_frame(3);
    pulse();                               // t+1 CHECK
    check("f1_busy_t1", int'(BUSY), 1);
    check("f1_done_t1", int'(UPDATE_DONE), 0);
    tick();                                // t+2 MOVE
    check("f1_bounce_t2", int'(BOUNCE), 0);
    check("f1_x_t2", int'(X_OUT), 280);
    tick();                                // t+3 DONE
    check("f1_done_t3", int'(UPDATE_DONE), 1);
    check("f1_busy_t3", int'(BUSY), 1);
    check("f1_x_t3", int'(X_OUT), 277);
    check("f1_y_t3", int'(Y_OUT), 197);
    tick();                                // t+4 IDLE
    check("f1_busy_t4", int'(BUSY), 0);
    check("f1_done_t4", int'(UPDATE_DONE), 0);

    for (int f = 2; f <= 66; f++) frame(3);
    check("f66_y", int'(Y_OUT), 8);
    check("f66_dir_y", int'(DIR_Y), 1);
    check("f66_x", int'(X_OUT), 82);
    check("f66_dir_x", int'(DIR_X), 0);

    for (int f = 67; f <= 92; f++) frame(3);
`ifdef MOTION_CLAMP_EN
    check("f92_x", int'(X_OUT), 5);
`else
    check("f92_x", int'(X_OUT), 4);
`endif
    frame(3);
`ifdef MOTION_CLAMP_EN
    check("f93_x", int'(X_OUT), 8);
`else
    check("f93_x", int'(X_OUT), 7);
`endif
    check("f93_dir_x", int'(DIR_X), 1);

    // Refresh held over t..t+2: one extra update starting at t+5.
    model_frame(3);
    model_frame(3);
    REFRESH = 1'b1;
    tick();
    tick();
    tick();                                // t+3
    REFRESH = 1'b0;
    check("pend_done_t3", int'(UPDATE_DONE), 1);
    tick();                                // t+4
    check("pend_busy_t4", int'(BUSY), 0);
    tick();                                // t+5
    check("pend_busy_t5", int'(BUSY), 1);
    wait_idle();
    repeat (8) tick();
    check("pend_no_third", int'(BUSY), 0);
    check("pend_queue_empty", exp_q.size(), 0);

    // Pause drops refreshes entirely.
    PAUSE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pulse();
      check("pause_busy", int'(BUSY), 0);
      tick();
    end
    PAUSE = 1'b0;
    repeat (4) tick();
    check("pause_no_pending", int'(BUSY), 0);
    check("pause_x_hold", int'(X_OUT), mx);
    check("pause_y_hold", int'(Y_OUT), my);
    frame(3);

    // Speed write during MOVE only affects the next frame.
    model_frame(3);
    pulse();                               // t+1 CHECK
    tick();                                // t+2 MOVE
    SPEED_WE = 1'b1;
    SPEED_IN = 4'd0;
    tick();
    SPEED_WE = 1'b0;
    wait_idle();
    frame(0);
    check("spd0_x_hold", int'(X_OUT), mx);

    // Reset in the middle of a sequence.
    pulse();                               // t+1 CHECK
    tick();                                // t+2 MOVE
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("mrst_x", int'(X_OUT), 280);
    check("mrst_y", int'(Y_OUT), 200);
    check("mrst_busy", int'(BUSY), 0);
    check("mrst_done", int'(UPDATE_DONE), 0);
    check("mrst_dir_x", int'(DIR_X), 0);
    mx = 280; my = 200; mdx = 0; mdy = 0;
    tick();
    check("mrst_idle", int'(BUSY), 0);
    frame(3);
    check("mrst_speed_x", int'(X_OUT), 277);

    repeat (5) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Frame-synchronous motion controller for the bouncing-sprite display path. Once per VGA frame it takes the refresh pulse from the VGA interface and runs a short state-machine sequence:

- checks the sprite against the screen walls,
- updates the direction bits,
- steps the position by a programmable speed.

X_OUT/Y_OUT feed the sprite window/address logic that generates COLOUR_IN. This replaces the free-running in-line position update with a sequenced, pausable, speed-configurable block.

## Interface
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- SPRITE_W, 80, sprite width
- SPRITE_H, 80, sprite height
- MARGIN, 5, wall guard band in pixels
- INIT_X, 280, reset X position
- INIT_Y, 200, reset Y position
- INIT_SPEED, 3, reset speed in pixels/frame

Ports:
- CLK  in  1  system clock; single clock domain
- RESET  in  1  synchronous, active-high reset
- REFRESH  in  1  one-cycle pulse per frame, from the VGA interface
- PAUSE  in  1  level; while high, frames are skipped
- SPEED_IN  in  4  new speed value
- SPEED_WE  in  1  one-cycle write strobe for SPEED_IN
- X_OUT  out  10  sprite left edge
- Y_OUT  out  9  sprite top edge
- DIR_X  out  1  1 = +X, 0 = −X
- DIR_Y  out  1  1 = +Y, 0 = −Y
- BOUNCE  out  1  one-cycle pulse when any direction bit changes
- UPDATE_DONE  out  1  one-cycle pulse when the new position is valid
- BUSY  out  1  high when the state is not IDLE

## Operation
- Limits, all compile-time constants:
  - XMIN = MARGIN, XMAX = SCREEN_W−1−SPRITE_W−MARGIN (554 with defaults).
  - YMIN = MARGIN, YMAX = SCREEN_H−1−SPRITE_H−MARGIN (394 with defaults).
- State machine: IDLE → CHECK → MOVE → DONE → IDLE.
- IDLE: leaves to CHECK when (REFRESH or PENDING) and !PAUSE. Entering CHECK clears PENDING.
- CHECK:
  - X ≥ XMAX → DIR_X=0; X ≤ XMIN → DIR_X=1.
  - Y ≥ YMAX → DIR_Y=0; Y ≤ YMIN → DIR_Y=1.
  - Registers a bounce flag if either direction bit changed.
  - Latches the speed into a working register.
- MOVE: X ± speed and Y ± speed, computed on 11-bit / 10-bit unsigned intermediates so subtraction cannot wrap. Results are written to X_OUT/Y_OUT at the end of MOVE.
- DONE: UPDATE_DONE=1, then return to IDLE.
- REFRESH arriving outside IDLE sets PENDING. Any number of such pulses collapse into one pending update.
- REFRESH while PAUSE=1 in IDLE is dropped: PENDING is not set and no update happens.
- Speed register:
  - SPEED_WE loads SPEED_IN in any state.
  - The new value takes effect at the next CHECK; the current frame keeps its latched speed.
  - Speed 0 is legal: position holds, but the wall check still runs.
- Simultaneous events:
  - SPEED_WE together with REFRESH in IDLE: the new speed is used for that frame.
  - RESET wins over everything.
- RESET, at any time including mid-sequence, restores on the next edge:
  - state = IDLE
  - X_OUT = INIT_X, Y_OUT = INIT_Y
  - DIR_X = 0, DIR_Y = 0
  - speed = INIT_SPEED
  - PENDING = 0, BOUNCE = 0, UPDATE_DONE = 0, BUSY = 0

## Timing
- REFRESH sampled high in IDLE at cycle t:
  - CHECK in t+1, MOVE in t+2, DONE in t+3.
  - BUSY is high for t+1..t+3.
- BOUNCE is high during t+2, and DIR_X/DIR_Y show their new values from t+2.
- X_OUT/Y_OUT change at the t+2→t+3 edge. UPDATE_DONE is high during t+3.
- A pending refresh starts CHECK at t+5: IDLE is spent for one cycle, t+4.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- MOTION_CLAMP_EN defined: MOVE saturates results to [XMIN, XMAX] and [YMIN, YMAX].
- MOTION_CLAMP_EN undefined: plain add/subtract. The position may overshoot a limit by up to speed−1 and reverses on the following frame. Results are still floored at 0 and capped at SCREEN−SPRITE.

## Test plan
- Reset release, then one REFRESH:
  - X_OUT 280→277, Y_OUT 200→197.
  - UPDATE_DONE is high exactly 3 cycles after REFRESH.
  - BOUNCE stays 0.
- Free run of 66 refreshes at speed 3:
  - Frame 66's CHECK sees Y=5 → DIR_Y=1, BOUNCE pulses, Y_OUT=8.
  - DIR_X stays 0 and X_OUT=82.
- Left-wall X bounce, continuing to frame 93:
  - With MOTION_CLAMP_EN: frame 92 gives X=5, frame 93 gives DIR_X=1 and X=8.
  - Without MOTION_CLAMP_EN: frame 92 gives X=4, frame 93 gives X=7.
- REFRESH pulsed again at t+1 and t+2 during a sequence: exactly one extra update, with CHECK at t+5, and no third update.
- PAUSE=1 over 10 REFRESH pulses: no BUSY, no UPDATE_DONE, position unchanged. After PAUSE drops, the next REFRESH steps by 3.
- SPEED_WE=1, SPEED_IN=0 during MOVE, then RESET asserted in the following MOVE:
  - The current frame steps by 3.
  - The next frame holds position.
  - The reset returns X_OUT=280, Y_OUT=200, speed=3, state IDLE.
